// File: rtl/linterp_engine.sv
// linterp_engine -- multi-channel, handshaked sequential linear interpolator.
//
// Computes base + (target - base) * frac / 2^INTERP_BITS using one shift-add
// step per frac bit, MSB first. The difference is formed at DATA_WIDTH+1 bits,
// so the full signed range never wraps. A channel tag travels with each job.
//
// Build option (macro LINTERP_ROUND_EN):
//   undefined : each shifted term is truncated toward zero in magnitude.
//   defined   : the exact |diff|*frac is accumulated, then rounded half away
//               from zero. Latency, handshake and ports are the same.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   in_valid     job offered
//   in_ready     engine can accept a job this cycle
//   in_channel   channel tag of the offered job
//   base         signed start value
//   target       signed end value
//   frac         unsigned interpolation fraction (of 2^INTERP_BITS)
//   out_valid    result held valid
//   out_ready    consumer takes the result
//   out_channel  tag of the result (not range-checked against CHANNELS)
//   interpolated signed result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The job source holds in_valid and its data until in_ready is
// seen; the result is held stable while out_valid & !out_ready.
// Latency: accept at edge 0 -> out_valid high after edge INTERP_BITS.
module linterp_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int INTERP_BITS = 4,
    parameter int CHANNELS    = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_channel,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] target,
    input  logic [INTERP_BITS-1:0] frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_channel,
    output logic [DATA_WIDTH-1:0] interpolated
);

    localparam int DW1   = DATA_WIDTH + 1;
    localparam int CNT_W = (INTERP_BITS > 1) ? $clog2(INTERP_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(INTERP_BITS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state;
    state_t state_next;

    logic                   accept;
    logic                   last_step;
    logic [CH_W-1:0]        ch_q;
    logic [DW1-1:0]         acc;      // running value (truncating) or base (rounding)
    logic [DW1-1:0]         mag;      // |target - base|
    logic                   sgn;      // target < base
    logic [INTERP_BITS-1:0] frac_sh;  // frac, shifted left each step; MSB is current bit
    logic [CNT_W-1:0]       cnt;

    logic [DW1-1:0] diff_in;
    logic [DW1-1:0] mag_in;
    logic [DW1-1:0] final_val;

    // Sign-extend both operands by one bit so the difference cannot wrap.
    assign diff_in = {target[DATA_WIDTH-1], target} - {base[DATA_WIDTH-1], base};
    assign mag_in  = diff_in[DW1-1] ? (~diff_in + DW1'(1)) : diff_in;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign last_step = (cnt == LAST_STEP);

`ifdef LINTERP_ROUND_EN
    localparam int PW = DW1 + INTERP_BITS;
    localparam logic [PW-1:0] HALF = PW'(1) << (INTERP_BITS - 1);

    logic [PW-1:0]  prod;
    logic [PW-1:0]  prod_step;
    logic [PW-1:0]  rnd_sum;
    logic [DW1-1:0] rnd_mag;

    // MSB-first shift-add builds the exact product |diff| * frac.
    assign prod_step = (prod << 1) + (frac_sh[INTERP_BITS-1] ? PW'(mag) : '0);
    assign rnd_sum   = prod_step + HALF;
    assign rnd_mag   = rnd_sum[PW-1:INTERP_BITS];
    assign final_val = sgn ? (acc - rnd_mag) : (acc + rnd_mag);
`else
    logic [DW1-1:0] term;
    logic [DW1-1:0] acc_step;

    // Step i contributes |diff| >> (i+1); shifting truncates toward zero.
    assign term      = (mag >> 1) >> cnt;
    assign acc_step  = frac_sh[INTERP_BITS-1] ? (sgn ? (acc - term) : (acc + term)) : acc;
    assign final_val = acc_step;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCUM;
            ACCUM:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = accept ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q         <= '0;
            acc          <= '0;
            mag          <= '0;
            sgn          <= 1'b0;
            frac_sh      <= '0;
            cnt          <= '0;
            interpolated <= '0;
`ifdef LINTERP_ROUND_EN
            prod         <= '0;
`endif
        end else if (accept) begin
            ch_q    <= in_channel;
            acc     <= {base[DATA_WIDTH-1], base};
            mag     <= mag_in;
            sgn     <= diff_in[DW1-1];
            frac_sh <= frac;
            cnt     <= '0;
`ifdef LINTERP_ROUND_EN
            prod    <= '0;
`endif
        end else if (state == ACCUM) begin
            frac_sh <= frac_sh << 1;
            cnt     <= cnt + CNT_W'(1);
`ifdef LINTERP_ROUND_EN
            prod    <= prod_step;
`else
            acc     <= acc_step;
`endif
            // The result lies between base and target, so the low bits hold it.
            if (last_step) interpolated <= final_val[DATA_WIDTH-1:0];
        end
    end

    assign out_channel = ch_q;

endmodule
